data_memory_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_array.sv | 34 +++
 rtl/data_memory_responder.sv | 129 ++++++++++++
 tb/tb_data_memory_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder and its RAM array.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous data RAM: registered read, write without read-back.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     index,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto RAM macros; only the read register clears.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[index] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle valid/ready responder in front of the data RAM.
// Optional out-of-range flagging is enabled by defining DMEM_BOUNDS_CHECK_EN.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              lat_write;
    logic [AW-1:0]     lat_index;
    logic [WORD_W-1:0] lat_wdata;
    logic              lat_err;
    logic              rdata_sel;
    logic              accept, access;
    logic [WORD_W-1:0] ram_rdata;
    logic              unused_addr_bits;

    // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                accept    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: if (cnt == '0) begin
                access    = 1'b1;
                state_nxt = RESP;
            end
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_index <= '0;
            lat_wdata <= '0;
            rdata_sel <= 1'b0;
        end else begin
            if (accept) begin
                lat_write <= req_write;
                lat_index <= req_addr[AW+1:2];
                lat_wdata <= req_wdata;
                cnt       <= CNT_W'(WAIT_CYCLES);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            // Store acks and rejected accesses report zero; loads expose the RAM read register.
            if (access) begin
                rdata_sel <= !lat_write && !lat_err;
            end
        end
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    logic addr_oob;
    logic err_q;

    assign addr_oob = {1'b0, req_addr} >= (33'(DEPTH) << 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_err <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            lat_err <= addr_oob;
            err_q   <= 1'b0;
        end else if (access) begin
            err_q   <= lat_err;
        end
    end

    assign resp_err = err_q;
`else
    assign lat_err  = 1'b0;
    assign resp_err = 1'b0;
`endif

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (access),
        .we    (lat_write && !lat_err),
        .index (lat_index),
        .wdata (lat_wdata),
        .rdata (ram_rdata)
    );

    assign req_ready        = (state == IDLE);
    assign busy             = !req_ready;
    assign resp_valid       = (state == RESP);
    assign resp_rdata       = rdata_sel ? ram_rdata : '0;
    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench: two responders (WAIT_CYCLES=2 and 0) behind one shared request driver.
module tb_data_memory_responder;

    localparam int DEPTH = 1024;
    localparam int WC    = 2;
`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0, sel_zero = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        m_req_ready, m_resp_valid, m_resp_err, m_busy;
    logic        z_req_ready, z_resp_valid, z_resp_err, z_busy;
    logic [31:0] m_resp_rdata, z_resp_rdata;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [2][DEPTH];
    bit          written   [2][DEPTH];

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    data_memory_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && !sel_zero), .req_ready(m_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(m_resp_valid), .resp_ready(resp_ready && !sel_zero),
        .resp_rdata(m_resp_rdata), .resp_err(m_resp_err), .busy(m_busy)
    );

    data_memory_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_zero (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && sel_zero), .req_ready(z_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(z_resp_valid), .resp_ready(resp_ready && sel_zero),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .busy(z_busy)
    );

    assign req_ready  = sel_zero ? z_req_ready  : m_req_ready;
    assign resp_valid = sel_zero ? z_resp_valid : m_resp_valid;
    assign resp_rdata = sel_zero ? z_resp_rdata : m_resp_rdata;
    assign resp_err   = sel_zero ? z_resp_err   : m_resp_err;
    assign busy       = sel_zero ? z_busy       : m_busy;

    // Word memory model: word index is the byte address divided by four, modulo DEPTH.
    function automatic void predict(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                    output logic [31:0] exp_rdata, output bit exp_err, output bit known);
        int s;
        int idx;
        s   = sel_zero ? 1 : 0;
        idx = int'((addr / 4) % DEPTH);
        exp_rdata = '0;
        exp_err   = 1'b0;
        known     = 1'b1;
        if (BOUNDS && addr >= 32'(DEPTH * 4)) begin
            exp_err = 1'b1;
        end else if (wr) begin
            model_mem[s][idx] = wdata;
            written[s][idx]   = 1'b1;
        end else begin
            exp_rdata = model_mem[s][idx];
            known     = written[s][idx];
        end
    endfunction

    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                       output logic [31:0] rdata, output bit err, output int lat,
                       output bit stable, output bit ok);
        int n;
        ok = 1'b1; stable = 1'b1; lat = 0; n = 0; rdata = '0; err = 1'b0;
        while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (req_ready !== 1'b1) begin ok = 1'b0; return; end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        while (resp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        if (resp_valid !== 1'b1) begin ok = 1'b0; return; end
        rdata = resp_rdata; err = resp_err;
        repeat (hold) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_rdata !== rdata || resp_err !== err || req_ready !== 1'b0)
                stable = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) stable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r, er; bit e, ee, k, st, ok; int lat;
        sel_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle: ready=%b busy=%b expected 1/0", req_ready, busy); end
        checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_outputs: valid=%b rdata=%h err=%b expected 0/0/0", resp_valid, resp_rdata, resp_err); end
        reset = 1'b0;
        @(posedge clk); #1;
        predict(1'b1, 32'h20, 32'h0BADF00D, er, ee, k);
        txn(1'b1, 32'h20, 32'h0BADF00D, 0, r, e, lat, st, ok);
        txn(1'b0, 32'h20, 32'h0, 0, r, e, lat, st, ok);
        checks++; if (!ok || r !== 32'h0BADF00D) begin errors++; $display("FAIL reset_preload: got %h expected 0badf00d (ok=%b)", r, ok); end
        // Start a store that is still waiting when reset hits.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h11112222;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_precond_busy: got %b expected 1", busy); end
        reset = 1'b1;
        #2;
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL reset_async_state: ready=%b busy=%b valid=%b expected 1/0/0", req_ready, busy, resp_valid); end
        checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_async_data: rdata=%h err=%b expected 0/0", resp_rdata, resp_err); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_after: ready=%b expected 1", req_ready); end
        txn(1'b0, 32'h20, 32'h0, 0, r, e, lat, st, ok);
        checks++; if (!ok || r !== 32'h0BADF00D) begin errors++; $display("FAIL reset_dropped_store: got %h expected 0badf00d (ok=%b)", r, ok); end
    endtask

    task automatic test_store_load();
        logic [31:0] r, er; bit e, ee, k, st, ok; int lat;
        sel_zero = 1'b0;
        predict(1'b1, 32'h10, 32'hDEADBEEF, er, ee, k);
        txn(1'b1, 32'h10, 32'hDEADBEEF, 0, r, e, lat, st, ok);
        checks++; if (!ok || lat !== WC + 1) begin errors++; $display("FAIL store_latency: got %0d expected %0d (ok=%b)", lat, WC + 1, ok); end
        checks++; if (r !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL store_ack: rdata=%h err=%b expected 0/0", r, e); end
        txn(1'b0, 32'h10, 32'h0, 0, r, e, lat, st, ok);
        checks++; if (!ok || lat !== WC + 1) begin errors++; $display("FAIL load_latency: got %0d expected %0d (ok=%b)", lat, WC + 1, ok); end
        checks++; if (r !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL load_data: rdata=%h err=%b expected deadbeef/0", r, e); end
    endtask

    task automatic test_backpressure();
        logic [31:0] r; bit e, st, ok; int lat, n;
        sel_zero = 1'b0; n = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (resp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_first: valid=%b rdata=%h expected 1/deadbeef", resp_valid, resp_rdata); end
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: valid=%b rdata=%h ready=%b expected 1/deadbeef/0", i, resp_valid, resp_rdata, req_ready); end
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_release: valid=%b ready=%b rdata=%h expected 0/1/deadbeef", resp_valid, req_ready, resp_rdata); end
        txn(1'b0, 32'h10, 32'h0, 0, r, e, lat, st, ok);
        checks++; if (!ok || r !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_ignored_store: got %h expected deadbeef (ok=%b)", r, ok); end
    endtask

    task automatic test_wrap();
        logic [31:0] r, er; bit e, ee, k, st, ok; int lat;
        sel_zero = 1'b0;
        predict(1'b1, 32'h0, 32'hA0A0A0A0, er, ee, k);
        txn(1'b1, 32'h0, 32'hA0A0A0A0, 0, r, e, lat, st, ok);
        predict(1'b1, 32'h1000, 32'h55, er, ee, k);
        txn(1'b1, 32'h1000, 32'h55, 0, r, e, lat, st, ok);
        checks++; if (!ok || e !== BOUNDS || r !== 32'h0 || lat !== WC + 1) begin errors++; $display("FAIL wrap_store: err=%b rdata=%h lat=%0d expected %b/0/%0d", e, r, lat, BOUNDS, WC + 1); end
        txn(1'b0, 32'h0, 32'h0, 0, r, e, lat, st, ok);
        checks++; if (!ok || r !== (BOUNDS ? 32'hA0A0A0A0 : 32'h55) || e !== 1'b0) begin errors++; $display("FAIL wrap_load: rdata=%h err=%b expected %h/0", r, e, BOUNDS ? 32'hA0A0A0A0 : 32'h55); end
        txn(1'b0, 32'h2000_0000, 32'h0, 1, r, e, lat, st, ok);
        checks++; if (!ok || r !== (BOUNDS ? 32'h0 : 32'h55) || e !== BOUNDS || !st) begin errors++; $display("FAIL wrap_high_load: rdata=%h err=%b stable=%b expected %h/%b/1", r, e, st, BOUNDS ? 32'h0 : 32'h55, BOUNDS); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] r, er; bit e, ee, k, st, ok; int lat;
        int acc [$];
        sel_zero = 1'b1;
        predict(1'b1, 32'h40, 32'hCAFEF00D, er, ee, k);
        txn(1'b1, 32'h40, 32'hCAFEF00D, 0, r, e, lat, st, ok);
        checks++; if (!ok || lat !== 1 || r !== 32'h0) begin errors++; $display("FAIL zw_store: lat=%0d rdata=%h expected 1/0 (ok=%b)", lat, r, ok); end
        txn(1'b0, 32'h40, 32'h0, 0, r, e, lat, st, ok);
        checks++; if (!ok || lat !== 1 || r !== 32'hCAFEF00D) begin errors++; $display("FAIL zw_load: lat=%0d rdata=%h expected 1/cafef00d (ok=%b)", lat, r, ok); end
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; resp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (req_ready === 1'b1) acc.push_back(i);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checks++; if (acc.size() !== 4) begin errors++; $display("FAIL zw_b2b_count: got %0d accepts expected 4", acc.size()); end
        for (int i = 1; i < acc.size(); i++) begin
            checks++; if (acc[i] - acc[i-1] !== 3) begin errors++; $display("FAIL zw_b2b_gap%0d: got %0d cycles expected 3", i, acc[i] - acc[i-1]); end
        end
        sel_zero = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] r, er, addr, wdata; bit e, ee, k, st, ok, wr; int lat, hold, exp_lat;
        for (int i = 0; i < 40; i++) begin
            sel_zero = (i % 4 == 3);
            wr    = 1'($urandom);
            addr  = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) addr = addr + 32'(DEPTH * 4) * $urandom_range(1, 3);
            wdata = $urandom;
            hold  = $urandom_range(0, 3);
            exp_lat = sel_zero ? 1 : WC + 1;
            predict(wr, addr, wdata, er, ee, k);
            txn(wr, addr, wdata, hold, r, e, lat, st, ok);
            checks++; if (!ok || lat !== exp_lat || !st) begin errors++; $display("FAIL rand%0d_timing: ok=%b lat=%0d stable=%b expected 1/%0d/1", i, ok, lat, st, exp_lat); end
            checks++; if (e !== ee || (k && r !== er)) begin errors++; $display("FAIL rand%0d_data: addr=%h wr=%b rdata=%h err=%b expected %h/%b", i, addr, wr, r, e, er, ee); end
        end
        sel_zero = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_backpressure();
        test_wrap();
        test_zero_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
